// File: rtl/muldiv_unit_if.sv
// Handshake and write-back bundle of the iterative RV32M multiply/divide unit.
// master: issuing side (start, op, operands, rd); slave: the unit (status, write-back).
interface muldiv_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   operand_a;
  logic [XLEN-1:0]   operand_b;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   wb_data;
  logic [ADDR_W-1:0] wb_address;
  logic              wb_enable;

  modport master (
    output start, funct3, operand_a, operand_b, rd_addr,
    input  busy, done, wb_data, wb_address, wb_enable
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, rd_addr,
    output busy, done, wb_data, wb_address, wb_enable
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, reset (sync, active-high), bus (slave: start/op/operands in, busy/done/wb out).
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [2:0]          r_f3;
  logic [ADDR_W-1:0]   r_rd;
  logic                r_sa;
  logic                r_sb;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_op;
  logic [XLEN-1:0]     r_res;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_wb_en;
  logic [XLEN-1:0]     r_wb_data;
  logic [ADDR_W-1:0]   r_wb_addr;

  // issue-side decode
  logic [2:0]          w_f3;
  logic [XLEN-1:0]     w_a;
  logic [XLEN-1:0]     w_b;
  logic                w_mul;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_div0;
  logic                w_ovf;
  logic [XLEN-1:0]     w_spec_res;

  always_comb begin
    w_f3    = bus.funct3;
    w_a     = bus.operand_a;
    w_b     = bus.operand_b;
    w_mul   = ~w_f3[2];
    // a unsigned only for MULHU/DIVU/REMU
    w_sgn_a = ~((w_f3 == 3'b011) | (w_f3[2] & w_f3[0]));
    // b signed only for MULH/DIV/REM
    w_sgn_b = (w_f3 == 3'b001) | (w_f3[2] & ~w_f3[0]);
    w_neg_a = w_sgn_a & w_a[XLEN-1];
    w_neg_b = w_sgn_b & w_b[XLEN-1];
    w_a_mag = w_neg_a ? -w_a : w_a;
    w_b_mag = w_neg_b ? -w_b : w_b;
    w_div0  = w_f3[2] & (w_b == '0);
    w_ovf   = w_f3[2] & ~w_f3[0]
            & (w_a == MIN_NEG) & (w_b == '1);
    w_spec_res = '0;
    if (w_div0) begin
      w_spec_res = w_f3[1] ? w_a : '1;
    end else if (w_ovf) begin
      w_spec_res = w_f3[1] ? '0 : MIN_NEG;
    end
  end

  // one iteration step
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [XLEN:0]       w_trial;
  logic [2*XLEN-1:0]   w_div_nxt;

  always_comb begin
    // multiply: acc = {partial, multiplier}; add then shift right
    w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
          + {1'b0, (r_acc[0] ? r_op : '0)};
    w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};
    // divide: acc = {remainder, dividend/quotient}
    w_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]}
            - {1'b0, r_op};
    if (!w_trial[XLEN]) begin
      w_div_nxt = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_div_nxt = {r_acc[2*XLEN-2:0], 1'b0};
    end
  end

  // sign fix-up and result select
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix_res;

  always_comb begin
    w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_quo  = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0]
                           : r_acc[XLEN-1:0];
    w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN]
                  : r_acc[2*XLEN-1:XLEN];
    w_fix_res = '0;
    unique case (1'b1)
      (r_f3 == 3'b000):
        w_fix_res = w_prod[XLEN-1:0];
      (~r_f3[2] & (r_f3[1:0] != 2'b00)):
        w_fix_res = w_prod[2*XLEN-1:XLEN];
      (r_f3[2] & ~r_f3[1]):
        w_fix_res = w_quo;
      (r_f3[2] & r_f3[1]):
        w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_f3      <= '0;
      r_rd      <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_acc     <= '0;
      r_op      <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_data <= '0;
      r_wb_addr <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wb_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_f3  <= w_f3;
            r_rd  <= bus.rd_addr;
            r_sa  <= w_neg_a;
            r_sb  <= w_neg_b;
            r_cnt <= '0;
            if (w_div0 | w_ovf) begin
              r_res   <= w_spec_res;
              r_state <= S_DONE;
            end else begin
              r_acc   <= w_mul ? {{XLEN{1'b0}}, w_b_mag}
                               : {{XLEN{1'b0}}, w_a_mag};
              r_op    <= w_mul ? w_a_mag : w_b_mag;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_f3[2] ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_res   <= w_fix_res;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_wb_en   <= (r_rd != '0);
          r_wb_data <= r_res;
          r_wb_addr <= r_rd;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.wb_data    = r_wb_data;
  assign bus.wb_address = r_wb_addr;
  assign bus.wb_enable  = r_wb_en;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Hand-computed RV32M results, latency, write-back and abort behaviour.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32), .ADDR_W(5)) bus();

  muldiv_unit #(.XLEN(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] got_data;
  logic [4:0]  got_addr;
  logic        got_en;
  int          got_lat;

  task automatic run_op(
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd
  );
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct3    = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.rd_addr   = rd;
    @(posedge clk);
    #1 bus.start = 1'b0;
    got_lat = 0;
    while (got_lat < 100) begin
      @(posedge clk);
      #1 got_lat++;
      if (bus.done) break;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL timeout f3=%b: no done in %0d edges",
               f3, got_lat);
    end
    got_data = bus.wb_data;
    got_addr = bus.wb_address;
    got_en   = bus.wb_enable;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.wb_enable,
         bus.wb_data, bus.wb_address} !== 40'd0) begin
      errors++;
      $display("FAIL reset_state: got b=%b d=%b e=%b data=%h a=%0d want all 0",
               bus.busy, bus.done, bus.wb_enable,
               bus.wb_data, bus.wb_address);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    checks++;
    if (got_lat !== 34) begin
      errors++;
      $display("FAIL mul_latency: got %0d want 34", got_lat);
    end
    checks++;
    if (got_data !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mul_data: got %h want ffffffeb", got_data);
    end
    checks++;
    if (got_addr !== 5'd5 || got_en !== 1'b1) begin
      errors++;
      $display("FAIL mul_wb: got addr=%0d en=%b want 5/1",
               got_addr, got_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wb_enable !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mul_pulse: got en=%b done=%b want 0/0",
               bus.wb_enable, bus.done);
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  f3s [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE,
                             32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'd1);
      checks++;
      if (got_data !== exp[i] || got_lat !== 34) begin
        errors++;
        $display("FAIL mulh_%0d: got %h lat=%0d want %h lat=34",
                 i, got_data, got_lat, exp[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'd2);
      checks++;
      if (got_data !== exp[i] || got_lat !== 34) begin
        errors++;
        $display("FAIL div_%0d: got %h lat=%0d want %h lat=34",
                 i, got_data, got_lat, exp[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'h1234, 32'h1234,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h1234,
                             32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'd3);
      checks++;
      if (got_data !== exp[i] || got_lat !== 1) begin
        errors++;
        $display("FAIL special_%0d: got %h lat=%0d want %h lat=1",
                 i, got_data, got_lat, exp[i]);
      end
    end
  endtask

  task automatic test_rd_zero();
    run_op(3'b000, 32'd3, 32'd4, 5'd0);
    checks++;
    if (got_data !== 32'd12 || got_en !== 1'b0
        || got_lat !== 34) begin
      errors++;
      $display("FAIL rd_zero: got %h en=%b lat=%0d want 0000000c en=0 lat=34",
               got_data, got_en, got_lat);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct3    = 3'b000;
    bus.operand_a = 32'h1234;
    bus.operand_b = 32'h10;
    bus.rd_addr   = 5'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b want 1", bus.busy);
    end
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (bus.done) break;
      if (lat == 9) begin
        bus.start     = 1'b1;
        bus.funct3    = 3'b100;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd5;
        bus.rd_addr   = 5'd9;
      end else if (lat == 10) begin
        bus.start = 1'b0;
      end
    end
    checks++;
    if (lat !== 34 || bus.wb_data !== 32'h12340
        || bus.wb_address !== 5'd7) begin
      errors++;
      $display("FAIL busy_ignore: got %h rd=%0d lat=%0d want 00012340 rd=7 lat=34",
               bus.wb_data, bus.wb_address, lat);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct3    = 3'b000;
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd9;
    bus.rd_addr   = 5'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got busy=%b done=%b want 0/0",
               bus.busy, bus.done);
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.wb_enable) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone: got done/wb_enable=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'b101, 32'd100, 32'd7, 5'd10);
    checks++;
    if (got_data !== 32'd14 || got_addr !== 5'd10
        || got_lat !== 34) begin
      errors++;
      $display("FAIL b2b_first: got %h rd=%0d lat=%0d want 0000000e rd=10 lat=34",
               got_data, got_addr, got_lat);
    end
    run_op(3'b111, 32'd100, 32'd7, 5'd11);
    checks++;
    if (got_data !== 32'd2 || got_addr !== 5'd11
        || got_en !== 1'b1 || got_lat !== 34) begin
      errors++;
      $display("FAIL b2b_second: got %h rd=%0d en=%b lat=%0d want 00000002 rd=11 en=1 lat=34",
               got_data, got_addr, got_en, got_lat);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.funct3    = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.rd_addr   = '0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_rd_zero();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
